// File: rtl/fmul_pipe.sv
// fmul_pipe: parametrised 3-stage IEEE-style floating-point multiplier.
// Round-to-nearest-even, denormals flushed to zero, valid/ready handshake.
module fmul_pipe #(
   parameter  int EXP_W  = 8,
   parameter  int FRAC_W = 23,
   localparam int W      = 1 + EXP_W + FRAC_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         flag_invalid,
   output logic         flag_overflow,
   output logic         flag_underflow,
   output logic         flag_inexact
);

   localparam int XW = EXP_W + 2;
   localparam int MW = FRAC_W + 1;
   localparam int PW = 2 * MW;
   localparam logic [XW-1:0]    BIAS  = XW'((1 << (EXP_W - 1)) - 1);
   localparam logic [EXP_W-1:0] EMAX  = '1;
   localparam logic [XW-1:0]    EMAXX = {2'b00, EMAX};
   localparam logic [W-1:0]     QNAN  = {1'b0, EMAX, 1'b1, {(FRAC_W-1){1'b0}}};

   logic w_adv;
   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;

   // ---- stage 1: classify operands, exponent sum ----
   logic [EXP_W-1:0]  w_ea, w_eb;
   logic [FRAC_W-1:0] w_fa, w_fb;
   logic w_za, w_zb, w_ia, w_ib, w_na, w_nb;
   logic [XW-1:0] w_exp1;

   assign w_ea   = a[W-2 -: EXP_W];
   assign w_eb   = b[W-2 -: EXP_W];
   assign w_fa   = a[FRAC_W-1:0];
   assign w_fb   = b[FRAC_W-1:0];
   assign w_za   = (w_ea == '0);
   assign w_zb   = (w_eb == '0);
   assign w_ia   = (w_ea == EMAX) && (w_fa == '0);
   assign w_ib   = (w_eb == EMAX) && (w_fb == '0);
   assign w_na   = (w_ea == EMAX) && (w_fa != '0);
   assign w_nb   = (w_eb == EMAX) && (w_fb != '0);
   assign w_exp1 = {2'b00, w_ea} + {2'b00, w_eb} - BIAS;

   logic          r1_v, r1_s, r1_inv, r1_inf, r1_zero;
   logic [XW-1:0] r1_exp;
   logic [MW-1:0] r1_ma, r1_mb;

   // ---- stage 2: full product, normalise, guard/round/sticky ----
   logic [PW-1:0] w_prod, w_norm;
   logic          w_msb;
   logic [XW-1:0] w_exp2;

   assign w_prod = {{MW{1'b0}}, r1_ma} * {{MW{1'b0}}, r1_mb};
   assign w_msb  = w_prod[PW-1];
   assign w_norm = w_msb ? w_prod : {w_prod[PW-2:0], 1'b0};
   assign w_exp2 = r1_exp + {{(XW-1){1'b0}}, w_msb};

   logic          r2_v, r2_s, r2_inv, r2_inf, r2_zero;
   logic          r2_g, r2_r, r2_st;
   logic [XW-1:0] r2_exp;
   logic [MW-1:0] r2_sig;

   // ---- stage 3: round to nearest even, range check, specials ----
   logic              w_up, w_lost, w_ovf, w_unf;
   logic [MW:0]       w_sum;
   logic [XW-1:0]     w_exp3;
   logic [FRAC_W-1:0] w_frac;
   logic [W-1:0]      w_res;
   logic [3:0]        w_fl;

   assign w_up   = r2_g & (r2_r | r2_st | r2_sig[0]);
   assign w_lost = r2_g | r2_r | r2_st;
   assign w_sum  = {1'b0, r2_sig} + {{MW{1'b0}}, w_up};
   assign w_exp3 = r2_exp + {{(XW-1){1'b0}}, w_sum[MW]};
   assign w_frac = w_sum[MW] ? w_sum[FRAC_W:1] : w_sum[FRAC_W-1:0];
   assign w_ovf  = !w_exp3[XW-1] && (w_exp3 >= EMAXX);
   assign w_unf  = w_exp3[XW-1] || (w_exp3 == '0);

   // pick final encoding and flags {invalid, overflow, underflow, inexact}
   always_comb begin
      w_res = {r2_s, w_exp3[EXP_W-1:0], w_frac};
      w_fl  = {3'b000, w_lost};
      if (r2_inv) begin
         w_res = QNAN;
         w_fl  = 4'b1000;
      end else if (r2_inf) begin
         w_res = {r2_s, EMAX, {FRAC_W{1'b0}}};
         w_fl  = 4'b0000;
      end else if (r2_zero) begin
         w_res = {r2_s, {(W-1){1'b0}}};
         w_fl  = 4'b0000;
      end else if (w_ovf) begin
         w_res = {r2_s, EMAX, {FRAC_W{1'b0}}};
         w_fl  = 4'b0101;
      end else if (w_unf) begin
         w_res = {r2_s, {(W-1){1'b0}}};
         w_fl  = 4'b0011;
      end
   end

   // slot-valid bits and output register; the only reset state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_v           <= 1'b0;
         r2_v           <= 1'b0;
         out_valid      <= 1'b0;
         result         <= '0;
         flag_invalid   <= 1'b0;
         flag_overflow  <= 1'b0;
         flag_underflow <= 1'b0;
         flag_inexact   <= 1'b0;
      end else if (w_adv) begin
         r1_v      <= in_valid;
         r2_v      <= r1_v;
         out_valid <= r2_v;
         if (r2_v) begin
            result         <= w_res;
            flag_invalid   <= w_fl[3];
            flag_overflow  <= w_fl[2];
            flag_underflow <= w_fl[1];
            flag_inexact   <= w_fl[0];
         end
      end
   end

   // datapath registers shift with the pipeline, no reset needed
   always_ff @(posedge clk) begin
      if (w_adv) begin
         r1_s    <= a[W-1] ^ b[W-1];
         r1_exp  <= w_exp1;
         r1_ma   <= {1'b1, w_fa};
         r1_mb   <= {1'b1, w_fb};
         r1_inv  <= w_na | w_nb | (w_ia & w_zb) | (w_ib & w_za);
         r1_inf  <= w_ia | w_ib;
         r1_zero <= w_za | w_zb;
         r2_s    <= r1_s;
         r2_exp  <= w_exp2;
         r2_sig  <= w_norm[PW-1:FRAC_W+1];
         r2_g    <= w_norm[FRAC_W];
         r2_r    <= w_norm[FRAC_W-1];
         r2_st   <= |w_norm[FRAC_W-2:0];
         r2_inv  <= r1_inv;
         r2_inf  <= r1_inf;
         r2_zero <= r1_zero;
      end
   end

endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: vector tables, scoreboarded random traffic, backpressure
// and mid-stream reset for fmul_pipe in single and half precision.
module tb_fmul_pipe;

   typedef longint unsigned u64;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [3:0]  f;
      string       nm;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a, b, result;
   logic        f_inv, f_ovf, f_unf, f_inx;
   logic [3:0]  fl;

   logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
   logic [15:0] h_a, h_b, h_result;
   logic        h_inv, h_ovf, h_unf, h_inx;
   logic [3:0]  hfl;

   assign fl  = {f_inv, f_ovf, f_unf, f_inx};
   assign hfl = {h_inv, h_ovf, h_unf, h_inx};

   fmul_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result),
      .flag_invalid(f_inv), .flag_overflow(f_ovf),
      .flag_underflow(f_unf), .flag_inexact(f_inx)
   );

   fmul_pipe #(.EXP_W(5), .FRAC_W(10)) dut_h (
      .clk(clk), .rst_n(rst_n),
      .in_valid(h_in_valid), .in_ready(h_in_ready),
      .a(h_a), .b(h_b),
      .out_valid(h_out_valid), .out_ready(h_out_ready),
      .result(h_result),
      .flag_invalid(h_inv), .flag_overflow(h_ovf),
      .flag_underflow(h_unf), .flag_inexact(h_inx)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int n_in, n_out;
   logic [35:0] exq[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Reference: exact integer significand product, RNE via remainder
   // compared to half an ulp. Returns {flags[3:0], result[31:0]}.
   function automatic logic [35:0] fref(input int E, input int F,
                                        input u64 x, input u64 y);
      u64 maxe, bias, fm, sx, sy, ex, ey, fx, fy, s, p, q, rem, half, r;
      longint e;
      int sh;
      bit nx, ny, ix, iy, zx, zy;
      logic [3:0] f;
      maxe = (u64'(1) << E) - 1;
      bias = (u64'(1) << (E - 1)) - 1;
      fm   = (u64'(1) << F) - 1;
      sx = (x >> (E + F)) & 64'd1;
      sy = (y >> (E + F)) & 64'd1;
      ex = (x >> F) & maxe;
      ey = (y >> F) & maxe;
      fx = x & fm;
      fy = y & fm;
      s  = sx ^ sy;
      nx = (ex == maxe) && (fx != 0);
      ny = (ey == maxe) && (fy != 0);
      ix = (ex == maxe) && (fx == 0);
      iy = (ey == maxe) && (fy == 0);
      zx = (ex == 0);
      zy = (ey == 0);
      f = 4'b0000;
      r = 0;
      if (nx || ny || (ix && zy) || (iy && zx)) begin
         r = (maxe << F) | (u64'(1) << (F - 1));
         f = 4'b1000;
      end else if (ix || iy) begin
         r = (s << (E + F)) | (maxe << F);
      end else if (zx || zy) begin
         r = s << (E + F);
      end else begin
         p = (fx | (u64'(1) << F)) * (fy | (u64'(1) << F));
         e = longint'(ex + ey) - longint'(bias);
         if (p >= (u64'(1) << (2 * F + 1))) begin
            sh = F + 1;
            e  = e + 1;
         end else begin
            sh = F;
         end
         q    = p >> sh;
         rem  = p & ((u64'(1) << sh) - 1);
         half = u64'(1) << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 1;
         if (q == (u64'(1) << (F + 1))) begin
            q = q >> 1;
            e = e + 1;
         end
         if (e >= longint'(maxe)) begin
            r = (s << (E + F)) | (maxe << F);
            f = 4'b0101;
         end else if (e <= 0) begin
            r = s << (E + F);
            f = 4'b0011;
         end else begin
            r = (s << (E + F)) | (u64'(e) << F) | (q & fm);
            f = {3'b000, rem != 0};
         end
      end
      return {f, r[31:0]};
   endfunction

   function automatic vec_t mkv(input logic [31:0] a_, input logic [31:0] b_,
                                input logic [31:0] r_, input logic [3:0] f_,
                                input string n_);
      vec_t v;
      v.a = a_; v.b = b_; v.r = r_; v.f = f_; v.nm = n_;
      return v;
   endfunction

   function automatic logic [31:0] rop32(input bit norm);
      int m;
      logic [7:0]  e;
      logic [22:0] f;
      m = norm ? 15 : int'($urandom_range(0, 15));
      f = 23'($urandom);
      case (m)
         0: e = 8'h00;
         1: begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 0) f = '0;
         end
         2: e = 8'h01;
         3: e = 8'hFE;
         4: begin
            e = 8'($urandom_range(100, 154));
            f = '0;
         end
         default: e = 8'($urandom_range(100, 154));
      endcase
      return {1'($urandom), e, f};
   endfunction

   function automatic logic [15:0] rop16();
      int m;
      logic [4:0] e;
      logic [9:0] f;
      m = int'($urandom_range(0, 11));
      f = 10'($urandom);
      case (m)
         0: e = 5'd0;
         1: begin
            e = 5'd31;
            if ($urandom_range(0, 1) == 0) f = '0;
         end
         2: e = 5'd1;
         3: e = 5'd30;
         default: e = 5'($urandom_range(8, 22));
      endcase
      return {1'($urandom), e, f};
   endfunction

   task automatic run32(input logic [31:0] ai, input logic [31:0] bi,
                        input logic [31:0] er, input logic [3:0] ef,
                        input string nm);
      int n;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a = ai;
      b = bi;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 10);
      chk({nm, " lat"}, 32'(n), 32'd3);
      chk({nm, " res"}, result, er);
      chk({nm, " flg"}, 32'(fl), 32'(ef));
   endtask

   task automatic run16(input logic [15:0] ai, input logic [15:0] bi,
                        input logic [15:0] er, input logic [3:0] ef,
                        input string nm);
      int n;
      @(negedge clk);
      h_in_valid = 1'b1;
      h_a = ai;
      h_b = bi;
      @(posedge clk);
      #1 h_in_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!h_out_valid && n < 10);
      chk({nm, " lat"}, 32'(n), 32'd3);
      chk({nm, " res"}, 32'(h_result), 32'(er));
      chk({nm, " flg"}, 32'(hfl), 32'(ef));
   endtask

   // sample handshakes 1 time unit after the negedge, then move one cycle
   task automatic step32();
      logic [35:0] e;
      if (in_valid && in_ready) begin
         exq.push_back(fref(8, 23, u64'(a), u64'(b)));
         n_in++;
      end
      if (out_valid && out_ready) begin
         n_out++;
         if (exq.size() == 0) begin
            chk("sb extra", 32'd1, 32'd0);
         end else begin
            e = exq.pop_front();
            chk("sb res", result, e[31:0]);
            chk("sb flg", 32'(fl), 32'(e[35:32]));
         end
      end
      @(negedge clk);
   endtask

   vec_t tv[12];
   vec_t th[5];
   logic [31:0] opa[6], opb[6];
   logic [31:0] held;
   logic [35:0] ev;
   logic [15:0] ha, hb;
   int k;
   bit stale;

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
      h_in_valid = 1'b0; h_a = '0; h_b = '0; h_out_ready = 1'b1;

      tv[0]  = mkv(32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0, "1.5x2");
      tv[1]  = mkv(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h1, "rne up");
      tv[2]  = mkv(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'h1, "rne tie");
      tv[3]  = mkv(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'h8, "inf x 0");
      tv[4]  = mkv(32'hFF800000, 32'h40000000, 32'hFF800000, 4'h0, "-inf x 2");
      tv[5]  = mkv(32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'h5, "ovf");
      tv[6]  = mkv(32'h00800000, 32'h3F000000, 32'h00000000, 4'h3, "unf");
      tv[7]  = mkv(32'h80800000, 32'h00400000, 32'h80000000, 4'h0, "denorm");
      tv[8]  = mkv(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'h8, "nan");
      tv[9]  = mkv(32'h40000000, 32'hC0400000, 32'hC0C00000, 4'h0, "2x-3");
      tv[10] = mkv(32'h3F7FFFFF, 32'h3F800001, 32'h3F800000, 4'h1, "rnd carry");
      tv[11] = mkv(32'h00800000, 32'h7F000000, 32'h40000000, 4'h0, "min x big");

      th[0] = mkv(32'h3E00, 32'h4000, 32'h4200, 4'h0, "h 1.5x2");
      th[1] = mkv(32'h7BFF, 32'h4000, 32'h7C00, 4'h5, "h ovf");
      th[2] = mkv(32'h3C00, 32'h3C00, 32'h3C00, 4'h0, "h 1x1");
      th[3] = mkv(32'hFC00, 32'h0000, 32'h7E00, 4'h8, "h inf x 0");
      th[4] = mkv(32'h0400, 32'h3800, 32'h0000, 4'h3, "h unf");

      // reset state
      #3;
      chk("rst ovalid", 32'(out_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst result", result, 32'd0);
      chk("rst flags", 32'(fl), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);

      // directed vectors
      for (int i = 0; i < 12; i++)
         run32(tv[i].a, tv[i].b, tv[i].r, tv[i].f, tv[i].nm);
      for (int i = 0; i < 5; i++)
         run16(th[i].a[15:0], th[i].b[15:0], th[i].r[15:0], th[i].f, th[i].nm);

      // random half precision against the model
      for (int i = 0; i < 30; i++) begin
         ha = rop16();
         hb = rop16();
         ev = fref(5, 10, u64'(ha), u64'(hb));
         run16(ha, hb, ev[15:0], ev[35:32], "h rand");
      end

      // backpressure: six back-to-back, stall output for a while
      for (int i = 0; i < 6; i++) begin
         opa[i] = rop32(1'b1);
         opb[i] = rop32(1'b1);
      end
      @(negedge clk);
      exq.delete();
      n_in = 0;
      n_out = 0;
      k = 0;
      held = '0;
      for (int t = 0; t < 60 && n_out < 6; t++) begin
         out_ready = !(t >= 2 && t < 8);
         in_valid  = (k < 6);
         if (k < 6) begin
            a = opa[k];
            b = opb[k];
         end
         #1;
         if (t == 3) begin
            chk("bp in_ready", 32'(in_ready), 32'd0);
            chk("bp ovalid", 32'(out_valid), 32'd1);
            held = result;
         end
         if (t > 3 && t < 8) begin
            chk("bp hold", result, held);
            chk("bp stall", 32'(in_ready), 32'd0);
         end
         if (in_valid && in_ready) k++;
         step32();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp count", 32'(n_out), 32'd6);
      chk("bp sent", 32'(n_in), 32'd6);
      chk("bp queue", 32'(exq.size()), 32'd0);

      // random traffic with random stalls
      n_in = 0;
      n_out = 0;
      for (int t = 0; t < 400; t++) begin
         in_valid  = ($urandom_range(0, 9) < 8);
         a = rop32(1'b0);
         b = rop32(1'b0);
         out_ready = ($urandom_range(0, 9) < 7);
         #1;
         step32();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int t = 0; t < 10 && exq.size() != 0; t++) begin
         #1;
         step32();
      end
      chk("rand drain", 32'(exq.size()), 32'd0);
      chk("rand count", 32'(n_out), 32'(n_in));

      // reset with three results in flight
      exq.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         a = rop32(1'b1);
         b = rop32(1'b1);
         #1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      #1;
      chk("mid busy", 32'(out_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid ovalid", 32'(out_valid), 32'd0);
      chk("mid result", result, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid in_ready", 32'(in_ready), 32'd1);
      stale = 1'b0;
      repeat (6) begin
         @(negedge clk);
         #1;
         if (out_valid) stale = 1'b1;
      end
      chk("mid stale", 32'(stale), 32'd0);
      run32(tv[0].a, tv[0].b, tv[0].r, tv[0].f, "mid new");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fmul_pipe.md
Name: fmul_pipe

Overview:
- Parametrised, pipelined floating-point multiplier. Successor to the single-precision combinational multiplier.
- Generalised to any exponent/fraction width. Adds round-to-nearest-even, NaN propagation and full IEEE exception flags.
- Uses a valid/ready handshake on both sides, so it sits between the operand issue logic and the result writeback in the FPU datapath.
- Fixed 3-stage pipeline, one result per cycle when not stalled.

Parameters:
- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1.
- FRAC_W, 23, stored fraction width; hidden bit is implicit.
- W, 1+EXP_W+FRAC_W (derived, not overridable), packed operand width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  W  operand A, packed {sign, exp, frac}.
- b  in  W  operand B, packed {sign, exp, frac}.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result this cycle.
- result  out  W  packed product.
- flag_invalid  out  1  invalid operation (inf*0, or any NaN operand).
- flag_overflow  out  1  rounded result exceeded max finite value.
- flag_underflow  out  1  result tiny, flushed to zero.
- flag_inexact  out  1  rounding discarded nonzero bits, or overflow/underflow occurred.

Behaviour:
- Reset (rst_n low, asynchronous): all stage-valid bits clear. out_valid=0, result=0, all flags=0. Operand registers are unreset.
- Reset mid-operation discards all in-flight results. After release, in_ready=1 on the first edge.
- Pipeline advance: advance = !out_valid || out_ready. in_ready = advance.
- Transfer on in_valid&&in_ready; output consumed on out_valid&&out_ready.
- All stages shift together on advance. A bubble (in_valid=0) propagates as an invalid slot.
- Latency: exactly 3 cycles from accept to out_valid with out_ready held high. Throughput 1/cycle.
- While stalled, result and flags hold stable.
- Stage 1: classify operands.
  - zero/denormal: exp==0 (denormals flushed to zero).
  - inf: exp all-ones, frac==0.
  - nan: exp all-ones, frac!=0.
  - sign = sA^sB.
  - Exponent sum computed at EXP_W+2 bits signed: eA+eB-bias.
  - Start (FRAC_W+1)x(FRAC_W+1) significand product.
- Stage 2:
  - Complete the 2*(FRAC_W+1)-bit product.
  - If the product MSB is set: shift right 1, exponent+1.
  - Form guard, round and sticky (OR of all lower bits).
- Stage 3: round to nearest, ties to even.
  - If rounding carries to 2.0: renormalise, exponent+1.
  - Then overflow/underflow checks, special-case override, register outputs.
- Special-case priority (highest first):
  - any NaN → canonical qNaN {0, all-ones, 1<<(FRAC_W-1)}, invalid=1.
  - inf*zero → canonical qNaN, invalid=1.
  - inf*x → signed inf.
  - zero*x → signed zero, no flags.
- Overflow: final biased exp >= 2^EXP_W-1 → signed inf, overflow=1, inexact=1.
- Underflow: final biased exp <= 0 → signed zero, underflow=1, inexact=1. No denormal outputs.
- Flags are valid only with out_valid and apply per result (not sticky).

Test Plan:
- Defaults, out_ready=1. a=0x3FC00000, b=0x40000000 → result 0x40400000 exactly 3 cycles later, all flags 0.
- a=0x3F800001, b=0x3F800001 → 0x3F800002, inexact=1. a=0x3F800003, b=0x3FC00000 (exact tie) → 0x3FC00004, inexact=1.
- Specials:
  - a=0x7F800000, b=0x00000000 → 0x7FC00000, invalid=1.
  - a=0xFF800000, b=0x40000000 → 0xFF800000, flags 0.
  - a=0x7F7FFFFF, b=0x40000000 → 0x7F800000, overflow=1, inexact=1.
- Underflow: a=0x00800000, b=0x3F000000 → 0x00000000, underflow=1, inexact=1. a=0x80800000, b=0x00400000 (denormal) → 0x80000000, no flags.
- Backpressure: stream 6 back-to-back operands.
  - Hold out_ready=0 from cycle 2 → in_ready drops once 3 results are held, output stable.
  - Release → all 6 results emerge in order, none lost or duplicated.
- Reset mid-stream: pull rst_n low while 3 results are in flight → out_valid=0 immediately (asynchronous). After release, no stale results appear and a new operand returns after 3 cycles.
- Parameter sweep: EXP_W=5, FRAC_W=10 (half precision). a=0x3E00, b=0x4000 → 0x4200. 0x7BFF*0x4000 → 0x7C00, overflow=1.
